// File: rtl/ip_axis_pkg.sv
// Shared types and constants for the AXI4-Stream loopback frame buffer.
package ip_axis_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 32;

  localparam logic [1:0] CMD_RX = 2'd1;
  localparam logic [1:0] CMD_TX = 2'd2;

  typedef enum logic [2:0] {
    ST_DEFAULT = 3'd0,
    ST_IN      = 3'd1,
    ST_W1      = 3'd2,
    ST_W2      = 3'd3,
    ST_IDLE    = 3'd4,
    ST_OUT     = 3'd5,
    ST_W3      = 3'd6,
    ST_W4      = 3'd7
  } state_t;

endpackage

// File: rtl/ip_frame_ram.sv
// Frame storage: one synchronous write port, one asynchronous read port, no reset.
module ip_frame_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/ip_axis_buffer.sv
// AXI4-Stream loopback buffer: captures a DEPTH-word frame and replays it with tlast.
// Optional macro IP_REVERSE_EN replays the frame in reverse word order.
module ip_axis_buffer
  import ip_axis_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int CNT_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  output logic              m_tlast,
  input  logic              m_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              en,
  input  logic              DMA_VALID,
  input  logic [1:0]        command
);

  // DEPTH is a power of two, so the last index is all ones.
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = {CNT_W{1'b1}};

  state_t            state_r, state_nx_s;
  logic [CNT_W-1:0]  wr_cnt_r, wr_cnt_nx_s;
  logic [CNT_W-1:0]  rd_cnt_r, rd_cnt_nx_s;
  logic [CNT_W-1:0]  rd_addr_s;
  logic              we_s;
  logic [DATA_W-1:0] rd_data_s;

`ifdef IP_REVERSE_EN
  assign rd_addr_s = CNT_LAST - rd_cnt_r;
`else
  assign rd_addr_s = rd_cnt_r;
`endif

  ip_frame_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (CNT_W)
  ) u_ram (
    .clk   (clk),
    .we    (we_s),
    .waddr (wr_cnt_r),
    .wdata (s_data),
    .raddr (rd_addr_s),
    .rdata (rd_data_s)
  );

  // State and counter registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r  <= ST_DEFAULT;
      wr_cnt_r <= '0;
      rd_cnt_r <= '0;
    end else begin
      state_r  <= state_nx_s;
      wr_cnt_r <= wr_cnt_nx_s;
      rd_cnt_r <= rd_cnt_nx_s;
    end
  end

  // Next-state, counter and write-enable logic; en=0 aborts from any active state
  always_comb begin
    state_nx_s  = state_r;
    wr_cnt_nx_s = wr_cnt_r;
    rd_cnt_nx_s = rd_cnt_r;
    we_s        = 1'b0;
    if (!en && (state_r != ST_DEFAULT)) begin
      state_nx_s  = ST_DEFAULT;
      wr_cnt_nx_s = '0;
      rd_cnt_nx_s = '0;
    end else begin
      case (state_r)
        ST_DEFAULT: begin
          if (en && DMA_VALID) state_nx_s = ST_IN;
          else                 state_nx_s = ST_DEFAULT;
        end
        ST_IN: begin
          if (s_valid) begin
            we_s = 1'b1;
            if (wr_cnt_r == CNT_LAST) begin
              wr_cnt_nx_s = '0;
              state_nx_s  = ST_W1;
            end else begin
              wr_cnt_nx_s = wr_cnt_r + CNT_ONE;
            end
          end else begin
            we_s = 1'b0;
          end
        end
        ST_W1: begin
          if (!DMA_VALID) state_nx_s = ST_W2;
          else            state_nx_s = ST_W1;
        end
        ST_W2: begin
          if (DMA_VALID) state_nx_s = ST_IDLE;
          else           state_nx_s = ST_W2;
        end
        ST_IDLE: begin
          if (!en && !DMA_VALID) begin
            state_nx_s = ST_DEFAULT;
          end else if (command == CMD_TX) begin
            state_nx_s  = ST_OUT;
            rd_cnt_nx_s = '0;
          end else if (command == CMD_RX) begin
            state_nx_s  = ST_IN;
            wr_cnt_nx_s = '0;
          end else begin
            state_nx_s = ST_IDLE;
          end
        end
        ST_OUT: begin
          if (m_ready) begin
            if (rd_cnt_r == CNT_LAST) begin
              rd_cnt_nx_s = '0;
              state_nx_s  = ST_W3;
            end else begin
              rd_cnt_nx_s = rd_cnt_r + CNT_ONE;
            end
          end else begin
            rd_cnt_nx_s = rd_cnt_r;
          end
        end
        ST_W3: begin
          if (!DMA_VALID) state_nx_s = ST_W4;
          else            state_nx_s = ST_W3;
        end
        ST_W4: begin
          if (DMA_VALID) state_nx_s = ST_IDLE;
          else           state_nx_s = ST_W4;
        end
        default: begin
          state_nx_s  = ST_DEFAULT;
          wr_cnt_nx_s = '0;
          rd_cnt_nx_s = '0;
        end
      endcase
    end
  end

  // Stream outputs decoded from the registered state; m_data is forced to zero outside OUT
  always_comb begin
    s_ready = 1'b0;
    m_valid = 1'b0;
    m_tlast = 1'b0;
    m_data  = '0;
    if (state_r == ST_IN) begin
      s_ready = 1'b1;
    end else if (state_r == ST_OUT) begin
      m_valid = 1'b1;
      m_tlast = (rd_cnt_r == CNT_LAST);
      m_data  = rd_data_s;
    end else begin
      s_ready = 1'b0;
    end
  end

endmodule

// File: tb/tb_ip_axis_buffer.sv
// Directed self-checking bench for ip_axis_buffer (honours IP_REVERSE_EN when defined).
module tb_ip_axis_buffer;

  localparam int DW    = 32;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_tlast;
  logic          m_ready = 1'b0;
  logic [DW-1:0] s_data = 32'd0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic          en = 1'b0;
  logic          DMA_VALID = 1'b0;
  logic [1:0]    command = 2'd0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ip_axis_buffer #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_tlast   (m_tlast),
    .m_ready   (m_ready),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .en        (en),
    .DMA_VALID (DMA_VALID),
    .command   (command)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_tx(input int base, input int beat);
`ifdef IP_REVERSE_EN
    return 32'(base + DEPTH - 1 - beat);
`else
    return 32'(base + beat);
`endif
  endfunction

  // Feed n consecutive words base..base+n-1; s_ready must drop only after the DEPTH-th write.
  task automatic rx_words(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = 32'(base + i);
      tick();
      check("rx_ready", {31'd0, s_ready}, {31'd0, (i != DEPTH - 1)});
    end
    s_valid = 1'b0;
  endtask

  // DMA_VALID low then high returns W1/W3 to IDLE.
  task automatic dma_handshake();
    DMA_VALID = 1'b0;
    tick();
    DMA_VALID = 1'b1;
    tick();
  endtask

  // Drain one frame over 50 cycles, optionally stalling m_ready for two cycles mid-frame.
  task automatic run_tx(input int base, input bit stall);
    int beat = 0;
    for (int c = 0; c < 50; c++) begin
      m_ready = !(stall && (c == 10 || c == 11));
      if (m_valid === 1'b1 && m_ready) begin
        check("tx_data", m_data, exp_tx(base, beat));
        check("tx_last", {31'd0, m_tlast}, {31'd0, (beat == DEPTH - 1)});
        beat++;
      end else if (!m_ready) begin
        check("tx_hold", m_data, exp_tx(base, beat));
      end
      tick();
    end
    m_ready = 1'b0;
    check("tx_beats", 32'(beat), 32'd32);
    check("tx_end_valid", {31'd0, m_valid}, 32'd0);
    check("tx_end_data", m_data, 32'd0);
  endtask

  initial begin
    @(negedge clk);
    repeat (5) tick();
    check("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("rst_m_tlast", {31'd0, m_tlast}, 32'd0);
    check("rst_s_ready", {31'd0, s_ready}, 32'd0);
    check("rst_m_data", m_data, 32'd0);

    rst = 1'b1;
    en  = 1'b1;
    repeat (3) tick();
    check("default_hold", {31'd0, s_ready}, 32'd0);

    DMA_VALID = 1'b1;
    tick();
    check("enter_in", {31'd0, s_ready}, 32'd1);
    rx_words(0, DEPTH);

    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1;
      s_data  = 32'hDEAD_0000 + 32'(i);
      tick();
      check("w1_ignore", {31'd0, s_ready}, 32'd0);
    end
    s_valid = 1'b0;

    dma_handshake();
    check("idle_m_valid", {31'd0, m_valid}, 32'd0);
    command = 2'd3;
    repeat (2) tick();
    check("noop_m_valid", {31'd0, m_valid}, 32'd0);
    check("noop_s_ready", {31'd0, s_ready}, 32'd0);

    command = 2'd2;
    tick();
    command = 2'd0;
    check("out_valid", {31'd0, m_valid}, 32'd1);
    check("out_first", m_data, exp_tx(0, 0));
    check("out_tlast", {31'd0, m_tlast}, 32'd0);
    tick();
    check("out_stall", m_data, exp_tx(0, 0));
    run_tx(0, 1'b1);

    dma_handshake();
    command = 2'd1;
    tick();
    command = 2'd0;
    check("rerx_ready", {31'd0, s_ready}, 32'd1);
    rx_words(32, DEPTH);
    dma_handshake();
    command = 2'd2;
    tick();
    command = 2'd0;
    run_tx(32, 1'b0);

    dma_handshake();
    en        = 1'b0;
    DMA_VALID = 1'b0;
    tick();
    check("shutdown_valid", {31'd0, m_valid}, 32'd0);
    en        = 1'b1;
    DMA_VALID = 1'b1;
    tick();
    check("restart_in", {31'd0, s_ready}, 32'd1);
    rx_words(32'h100, 10);
    en = 1'b0;
    tick();
    check("abort_ready", {31'd0, s_ready}, 32'd0);
    tick();
    check("abort_hold", {31'd0, s_ready}, 32'd0);

    en = 1'b1;
    tick();
    check("rx_after_abort", {31'd0, s_ready}, 32'd1);
    rx_words(32'h200, DEPTH);
    dma_handshake();
    command = 2'd2;
    tick();
    command = 2'd0;
    run_tx(32'h200, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ip_axis_buffer.md
Name: ip_axis_buffer

Overview:
- AXI4-Stream loopback buffer between a DMA engine and the fabric.
- In a receive phase it captures a fixed-length frame of DEPTH 32-bit words from the slave stream into an internal memory.
- In a transmit phase it replays that frame on the master stream, with tlast on the final word.
- DMA_VALID handshake phases and a 2-bit command select the phase; en enables the block.

Parameters:
- DATA_W, 32, stream data width.
- DEPTH, 32, words per frame (power of two, at least 2).
- CNT_W, $clog2(DEPTH), word counter width.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset; synchronous, active-low.
- m_data  output  DATA_W  master stream data, driven by the block toward the DMA.
- m_valid  output  1  master stream valid.
- m_tlast  output  1  last word of the outgoing frame.
- m_ready  input  1  downstream ready.
- s_data  input  DATA_W  slave stream data, from the DMA.
- s_valid  input  1  slave stream valid.
- s_ready  output  1  block ready to accept.
- en  input  1  block enable.
- DMA_VALID  input  1  DMA phase/handshake level.
- command  input  2  1 = receive frame, 2 = transmit frame; 0 and 3 = no-op.

Behaviour:
- Reset (rst=0 at a posedge): state DEFAULT, wr_cnt=0, rd_cnt=0. m_valid=0, m_tlast=0, s_ready=0, m_data=0. Memory contents are not cleared.
- States: DEFAULT, IN, W1, W2, IDLE, OUT, W3, W4. Registered state; outputs are decoded from the state.
- DEFAULT -> IN when en=1 and DMA_VALID=1.
- IN: s_ready=1.
  - Each cycle with s_valid=1 writes s_data to mem[wr_cnt] and increments wr_cnt.
  - The write with wr_cnt=DEPTH-1 wraps wr_cnt to 0 and moves to W1 next cycle.
- W1: s_ready=0; further s_valid beats are ignored. -> W2 when DMA_VALID=0.
- W2 -> IDLE when DMA_VALID=1.
- IDLE: priority order, highest first:
  - en=0 and DMA_VALID=0 -> DEFAULT.
  - command=2 -> OUT, rd_cnt=0.
  - command=1 -> IN, wr_cnt=0.
  - Otherwise stay.
- OUT:
  - m_valid=1; m_data=mem[rd_cnt], combinational read.
  - m_tlast=1 iff rd_cnt=DEPTH-1.
  - On m_valid and m_ready, rd_cnt increments.
  - The handshake with tlast wraps rd_cnt to 0 and moves to W3.
  - m_data must be held stable while m_ready=0.
- W3: m_valid=0, m_tlast=0. -> W4 when DMA_VALID=0.
- W4 -> IDLE when DMA_VALID=1.
- Outside IN: s_ready=0. Outside OUT: m_valid=0, m_tlast=0, m_data=0.
- en=0 in any state other than DEFAULT: abort to DEFAULT next cycle and clear both counters. rst has priority over en.
- OUT entered without a prior IN transmits the current memory contents; no error flag.
- The full frame is always transferred. There is no early termination by s_tlast (no such port).

Optional Feature:
- Macro IP_REVERSE_EN.
- Defined: OUT reads mem[DEPTH-1-rd_cnt], so the frame is replayed in reverse order. tlast still marks the DEPTH-th beat.
- Undefined: in-order replay as above.

Decomposition:
- Package ip_axis_pkg: state enum typedef, CMD_RX=2'd1, CMD_TX=2'd2, default DEPTH/DATA_W constants.
- One sub-module, ip_frame_ram: DEPTH x DATA_W, one synchronous write port and one asynchronous read port.
- FSM and counters stay in the top module.

Test Plan:
- Reset/idle: hold rst=0 for 5 cycles -> all outputs 0, state DEFAULT. Raise en=1 with DMA_VALID=0 -> remains DEFAULT, s_ready=0.
- Receive: en=1, DMA_VALID=1 -> s_ready=1 next cycle. Stream s_data=0..31 with s_valid continuous -> 32 writes, then s_ready=0. Extra beats with s_valid=1 for 5 cycles are not written.
- DMA handshake: in W1 drop DMA_VALID, then raise it -> IDLE. Then command=2 -> m_valid=1, m_data=0, m_tlast=0.
- Transmit: m_ready=1 for 50 cycles -> exactly 32 beats with m_data=0..31. m_tlast=1 only with m_data=31, then m_valid=0. Toggle m_ready low mid-frame -> m_data holds.
- Re-receive: from IDLE, command=1, stream 32..63 -> second transmit gives 32..63 with tlast on 63. With IP_REVERSE_EN defined: 63..32, tlast on 32.
- Shutdown/abort: in IDLE, en=0 and DMA_VALID=0 -> DEFAULT. Drop en=0 mid-IN after 10 words -> DEFAULT, s_ready=0. The next receive restarts at address 0.
